// File: rtl/avg_mag_store_pkg.sv
// Shared constants and FSM encoding for the averaged-magnitude store.
package avg_mag_store_pkg;

    localparam int NCH   = 32;
    localparam int CH_W  = 5;
    localparam int DMS_W = 12;
    localparam int DML_W = 14;
    localparam int FI_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/avg_mag_store_if.sv
// Update handshake and read port of the averaged-magnitude store.
interface avg_mag_store_if;
    import avg_mag_store_pkg::*;

    logic             upd_valid;
    logic             upd_ready;
    logic [CH_W-1:0]  upd_ch;
    logic [FI_W-1:0]  upd_fi;
    logic             upd_done;
    logic [CH_W-1:0]  rd_ch;
    logic [DMS_W-1:0] rd_dms;
    logic [DML_W-1:0] rd_dml;

    modport master (
        output upd_valid, upd_ch, upd_fi, rd_ch,
        input  upd_ready, upd_done, rd_dms, rd_dml
    );

    modport slave (
        input  upd_valid, upd_ch, upd_fi, rd_ch,
        output upd_ready, upd_done, rd_dms, rd_dml
    );

endinterface

// File: rtl/avg_filt.sv
// Combinational short/long-term average update: each average moves toward
// the scaled F(I) value by a fixed fraction of the difference, with the
// difference treated as two's complement (top bit = sign) and all sums
// wrapping at the register width.
module avg_filt
    import avg_mag_store_pkg::*;
(
    input  logic [FI_W-1:0]  fi,
    input  logic [DMS_W-1:0] dms,
    input  logic [DML_W-1:0] dml,
    output logic [DMS_W-1:0] dmsp,
    output logic [DML_W-1:0] dmlp
);

    // One bit wider than the average so the wrap-around difference keeps its sign bit.
    logic [DMS_W:0] dif_s;
    logic [DML_W:0] dif_l;

    assign dif_s = {1'b0, fi, 9'd0}  - {1'b0, dms};
    assign dif_l = {1'b0, fi, 11'd0} - {1'b0, dml};

    // Arithmetic shift by 5 (short) / 7 (long): a negative difference fills the top bits with ones.
    assign dmsp = DMS_W'((dif_s >> 5) + (dif_s[DMS_W] ? 13'd3840  : 13'd0) + {1'b0, dms});
    assign dmlp = DML_W'((dif_l >> 7) + (dif_l[DML_W] ? 15'd16128 : 15'd0) + {1'b0, dml});

endmodule

// File: rtl/avg_mag_store.sv
// Per-channel store of short-term (DMS) and long-term (DML) magnitude
// averages. One update at a time runs IDLE -> FETCH -> CALC -> WRITE;
// a registered read port returns the stored pair for any channel.
module avg_mag_store #(
    parameter int NCH = avg_mag_store_pkg::NCH
) (
    input  logic            clk,
    input  logic            reset,
    avg_mag_store_if.slave  bus
);
    import avg_mag_store_pkg::*;

    state_t           state;
    logic             done_r;
    logic [CH_W-1:0]  ch_lat;
    logic [FI_W-1:0]  fi_lat;
    logic [DMS_W-1:0] dms_p0;
    logic [DML_W-1:0] dml_p0;
    logic [DMS_W-1:0] dmsp_c;
    logic [DML_W-1:0] dmlp_c;
    logic [DMS_W-1:0] dmsp_p1;
    logic [DML_W-1:0] dmlp_p1;
    logic [DMS_W-1:0] rd_dms_r;
    logic [DML_W-1:0] rd_dml_r;
    logic [DMS_W-1:0] dms_mem [NCH];
    logic [DML_W-1:0] dml_mem [NCH];
    logic             accept;
    logic             ch_ok;
    logic             rd_ok;

    // Channels beyond the array still run the full sequence but never touch storage.
    assign accept        = (state == ST_IDLE) && bus.upd_valid;
    assign ch_ok         = int'(ch_lat) < NCH;
    assign rd_ok         = int'(bus.rd_ch) < NCH;
    assign bus.upd_ready = (state == ST_IDLE);
    assign bus.upd_done  = done_r;
    assign bus.rd_dms    = rd_dms_r;
    assign bus.rd_dml    = rd_dml_r;

    avg_filt u_filt (
        .fi   (fi_lat),
        .dms  (dms_p0),
        .dml  (dml_p0),
        .dmsp (dmsp_c),
        .dmlp (dmlp_c)
    );

    // Sequencer: upd_done is high for the whole WRITE cycle, so a reset during FETCH/CALC leaves it low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.upd_valid) state <= ST_FETCH;
                end
                ST_FETCH: state <= ST_CALC;
                ST_CALC: begin
                    state  <= ST_WRITE;
                    done_r <= 1'b1;
                end
                ST_WRITE: begin
                    state  <= ST_IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Request latch, fetch (p0) and filter result (p1) stages; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            ch_lat <= bus.upd_ch;
            fi_lat <= bus.upd_fi;
        end
        // stage p0: stored averages of the latched channel
        if (state == ST_FETCH) begin
            dms_p0 <= ch_ok ? dms_mem[ch_lat] : '0;
            dml_p0 <= ch_ok ? dml_mem[ch_lat] : '0;
        end
        // stage p1: updated averages
        if (state == ST_CALC) begin
            dmsp_p1 <= dmsp_c;
            dmlp_p1 <= dmlp_c;
        end
    end

    // Average storage: cleared by reset, written at the end of WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                dms_mem[i] <= '0;
                dml_mem[i] <= '0;
            end
        end else if (state == ST_WRITE && ch_ok) begin
            dms_mem[ch_lat] <= dmsp_p1;
            dml_mem[ch_lat] <= dmlp_p1;
        end
    end

    // Registered read port: samples the array before any same-edge write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_dms_r <= '0;
            rd_dml_r <= '0;
        end else begin
            rd_dms_r <= rd_ok ? dms_mem[bus.rd_ch] : '0;
            rd_dml_r <= rd_ok ? dml_mem[bus.rd_ch] : '0;
        end
    end

endmodule

// File: doc/avg_mag_store.md
AVG_MAG_STORE -- requirements
Module: avg_mag_store

Interface
REQ-001 SHALL have parameter NCH, default 32, meaning number of channels held (5-bit channel index).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port upd_valid, input, 1, update request for channel upd_ch.
REQ-005 SHALL have port upd_ready, output, 1, block accepts a request this cycle.
REQ-006 SHALL have port upd_ch, input, 5, channel to update.
REQ-007 SHALL have port upd_fi, input, 3, F(I) magnitude-function value for the update.
REQ-008 SHALL have port upd_done, output, 1, one-cycle pulse when the new state is written.
REQ-009 SHALL have port rd_ch, input, 5, channel to read.
REQ-010 SHALL have port rd_dms, output, 12, short-term average DMS of rd_ch, registered.
REQ-011 SHALL have port rd_dml, output, 14, long-term average DML of rd_ch, registered.

Function
REQ-012 SHALL hold per channel one 12-bit DMS and one 14-bit DML in a flop array.
REQ-013 SHALL run FSM IDLE -> FETCH -> CALC -> WRITE -> IDLE; upd_ready=1 only in IDLE.
REQ-014 SHALL accept a request when upd_valid && upd_ready, latching upd_ch and upd_fi; go to FETCH.
REQ-015 FETCH SHALL register the stored DMS/DML of the latched channel; CALC SHALL register DMSP/DMLP; WRITE SHALL store them and assert upd_done.
REQ-016 Latency SHALL be exactly 3 cycles from accept edge to upd_done; next accept possible the cycle after upd_done.
REQ-017 DMSP SHALL be: DIF=((FI<<9)+8192-DMS) mod 8192; DIFSX = DIF[12] ? (DIF>>5)+3840 : DIF>>5; DMSP=(DIFSX+DMS) mod 4096.
REQ-018 DMLP SHALL be: DIF=((FI<<11)+32768-DML) mod 32768; DIFSX = DIF[14] ? (DIF>>7)+16128 : DIF>>7; DMLP=(DIFSX+DML) mod 16384.
REQ-019 All arithmetic SHALL be unsigned and wrap at the stated moduli; no saturation.
REQ-020 rd_dms/rd_dml SHALL present the array contents for rd_ch one cycle after rd_ch is sampled.
REQ-021 If rd_ch equals the channel written in the same cycle, the read SHALL return the old value; the new value appears on the following read.
REQ-022 upd_valid while busy SHALL be ignored (not queued); requester holds it until upd_ready.
REQ-023 upd_ch >= NCH SHALL be accepted, complete with upd_done, and write nothing.

Reset
REQ-024 reset SHALL immediately clear every DMS/DML entry to 0, FSM to IDLE, upd_done to 0, rd_dms/rd_dml to 0, upd_ready to 1 after release.
REQ-025 reset asserted mid-update SHALL abort it with no write and no upd_done.

Structure
REQ-026 Shared package SHALL hold NCH, DMS_W=12, DML_W=14, FI_W=3 and the FSM state enum.
REQ-027 The DMSP/DMLP arithmetic SHALL live in one combinational sub-module avg_filt (inputs fi, dms, dml; outputs dmsp, dmlp).

Verification
REQ-028 Reset, then rd_ch=0 -> rd_dms=0, rd_dml=0; upd_ready=1.
REQ-029 upd ch=0 fi=7 -> upd_done 3 cycles after accept; then read ch0 -> dms=112, dml=112.
REQ-030 Then upd ch=0 fi=0 -> dms=108, dml=111 (sign-extension path).
REQ-031 upd_valid held during busy with ch=1 -> exactly one extra update after upd_ready returns; ch1 only updated once.
REQ-032 reset pulsed in CALC of a ch=2 update -> no upd_done, ch2 reads 0, all channels 0.
REQ-033 rd_ch=3 during WRITE of ch3 -> old value that cycle, new value next cycle; reference model compares 1000 random updates over all channels.
